// File: rtl/mbus_sram_arbiter.sv
// mbus_sram_arbiter: owns the 8-bit multiplexed external SRAM bus (address
// latch + 128x4 SRAM) and shares it between port A (CPU core) and port B
// (loader/debug engine) with round-robin arbitration. Every access runs
// IDLE -> ADDR -> DATA -> DONE -> IDLE, and all outputs are registered.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request (held until a_ack)
//   a_ack, a_rdata              port A completion pulse and read data
//   b_req/b_we/b_addr/b_wdata   port B request (held until b_ack)
//   b_ack, b_rdata              port B completion pulse and read data
//   bus_out                     [7]=1: address phase, [6:0]=addr
//                               [7]=0: data phase, [5]=we_n, [4]=strobe_n, [3:0]=wdata
//   bus_in                      SRAM read data
//   busy                        high whenever the FSM is not idle
//   grant_b                     0: port A owns/last owned the bus, 1: port B
module mbus_sram_arbiter #(
  parameter int unsigned ADDR_CYCLES = 1,
  parameter int unsigned DATA_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [6:0] a_addr,
  input  logic [3:0] a_wdata,
  output logic       a_ack,
  output logic [3:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [6:0] b_addr,
  input  logic [3:0] b_wdata,
  output logic       b_ack,
  output logic [3:0] b_rdata,
  output logic [7:0] bus_out,
  input  logic [3:0] bus_in,
  output logic       busy,
  output logic       grant_b
);

  localparam int unsigned AW   = 7;
  localparam int unsigned DW   = 4;
  localparam int unsigned BW   = 8;
  localparam int unsigned MAXC = (ADDR_CYCLES > DATA_CYCLES) ? ADDR_CYCLES : DATA_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  localparam logic [BW-1:0] BUS_IDLE  = 8'h30;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_CYCLES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gnt_b_q, gnt_b_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   bus_q, bus_d;
  logic            a_ack_q, a_ack_d;
  logic            b_ack_q, b_ack_d;
  logic [DW-1:0]   a_rdata_q, a_rdata_d;
  logic [DW-1:0]   b_rdata_q, b_rdata_d;
  logic            busy_q, busy_d;
  logic            pick_b;

  // State and output registers; reset leaves the bus idle with A favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt_b_q   <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_q     <= BUS_IDLE;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_b_q   <= gnt_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bus_q     <= bus_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_b_d   = gnt_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    pick_b    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          // On a tie the port that did not own the bus last wins.
          pick_b  = b_req && (!a_req || !gnt_b_q);
          gnt_b_d = pick_b;
          we_d    = pick_b ? b_we    : a_we;
          addr_d  = pick_b ? b_addr  : a_addr;
          wdata_d = pick_b ? b_wdata : a_wdata;
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          a_ack_d = !gnt_b_q;
          b_ack_d = gnt_b_q;
          // Read data is taken on the last data cycle, together with the ack.
          if (!we_q) begin
            if (gnt_b_q) b_rdata_d = bus_in;
            else         a_rdata_d = bus_in;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus drive follows the state being entered so it lines up with the state register.
    case (state_d)
      S_ADDR:  bus_d = {1'b1, addr_d};
      S_DATA:  bus_d = {2'b00, ~we_d, 1'b0, (we_d ? wdata_d : 4'h0)};
      default: bus_d = BUS_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign bus_out = bus_q;
  assign busy    = busy_q;
  assign grant_b = gnt_b_q;

endmodule

// File: tb/tb_mbus_sram_arbiter.sv
`timescale 1ns/1ps
module tb_mbus_sram_arbiter;

  localparam int unsigned T_ADDR = 1;
  localparam int unsigned T_DATA = 2;

  typedef struct packed {
    logic       we;
    logic [3:0] rdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [6:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_ack, b_ack;
  logic [3:0] a_rdata, b_rdata;
  logic [7:0] bus_out;
  logic [3:0] bus_in;
  logic       busy, grant_b;

  // Second instance with stretched phases.
  logic       a_req6, a_we6;
  logic [6:0] a_addr6;
  logic [3:0] a_wdata6;
  logic       a_ack6, b_ack6;
  logic [3:0] a_rdata6, b_rdata6;
  logic [7:0] bus_out6;
  logic       busy6, grant_b6;
  logic       b_req6 = 1'b0;
  logic       b_we6 = 1'b0;
  logic [6:0] b_addr6 = 7'h00;
  logic [3:0] b_wdata6 = 4'h0;
  logic [3:0] bus_in6 = 4'h9;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic prev_addr = 1'b0;

  logic [7:0] exp_bus_q[$];
  exp_t       exp_a_q[$];
  exp_t       exp_b_q[$];

  always #5 clk = ~clk;

  mbus_sram_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .bus_out(bus_out), .bus_in(bus_in), .busy(busy), .grant_b(grant_b)
  );

  mbus_sram_arbiter #(.ADDR_CYCLES(2), .DATA_CYCLES(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req6), .a_we(a_we6), .a_addr(a_addr6), .a_wdata(a_wdata6),
    .a_ack(a_ack6), .a_rdata(a_rdata6),
    .b_req(b_req6), .b_we(b_we6), .b_addr(b_addr6), .b_wdata(b_wdata6),
    .b_ack(b_ack6), .b_rdata(b_rdata6),
    .bus_out(bus_out6), .bus_in(bus_in6), .busy(busy6), .grant_b(grant_b6)
  );

  // External address latch + 128x4 SRAM.
  logic [3:0] mem [128] = '{default: 4'h0};
  logic [6:0] sram_addr = 7'h00;
  assign bus_in = mem[sram_addr];
  always @(posedge clk) begin
    if (bus_out[7]) sram_addr <= bus_out[6:0];
    else if (!bus_out[5] && !bus_out[4]) mem[sram_addr] <= bus_out[3:0];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
  endtask

  task automatic exp_xact(input logic [7:0] ab, input logic [7:0] db);
    for (int i = 0; i < int'(T_ADDR); i++) exp_bus_q.push_back(ab);
    for (int i = 0; i < int'(T_DATA); i++) exp_bus_q.push_back(db);
  endtask

  // Port A requester; called just after a rising edge, returns just after one.
  task automatic a_xact(input logic we, input logic [6:0] addr, input logic [3:0] wd,
                        input logic [3:0] exp_rd);
    exp_t e;
    bit   got;
    e.we = we; e.rdata = exp_rd;
    exp_a_q.push_back(e);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = a_ack;
    end
    if (!got) fail("a_ack_timeout", 32'(a_ack));
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic b_xact(input logic we, input logic [6:0] addr, input logic [3:0] wd,
                        input logic [3:0] exp_rd);
    exp_t e;
    bit   got;
    e.we = we; e.rdata = exp_rd;
    exp_b_q.push_back(e);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = b_ack;
    end
    if (!got) fail("b_ack_timeout", 32'(b_ack));
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  // Monitor: bus trace, busy, ack latency/ownership and read data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_addr = 1'b0;
    end else begin
      if (bus_out != 8'h30) begin
        if (exp_bus_q.size() == 0) fail("bus_unexpected", 32'(bus_out));
        else check("bus_out", 32'(bus_out), 32'(exp_bus_q.pop_front()));
        if (bus_out[7] && !prev_addr) start_cyc = cyc;
      end
      prev_addr = bus_out[7];
      check("busy", 32'(busy), 32'((bus_out != 8'h30) || a_ack || b_ack));
      if (a_ack || b_ack) begin
        check("ack_overlap", 32'(a_ack & b_ack), 32'd0);
        check("ack_latency", 32'(cyc - start_cyc), 32'(T_ADDR + T_DATA));
      end
      if (a_ack) begin
        check("grant_b_at_a_ack", 32'(grant_b), 32'd0);
        if (exp_a_q.size() == 0) fail("a_ack_unexpected", 32'(a_ack));
        else begin
          e = exp_a_q.pop_front();
          if (!e.we) check("a_rdata", 32'(a_rdata), 32'(e.rdata));
        end
      end
      if (b_ack) begin
        check("grant_b_at_b_ack", 32'(grant_b), 32'd1);
        if (exp_b_q.size() == 0) fail("b_ack_unexpected", 32'(b_ack));
        else begin
          e = exp_b_q.pop_front();
          if (!e.we) check("b_rdata", 32'(b_rdata), 32'(e.rdata));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [7:0] exp6;
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    a_req6 = 0; a_we6 = 0; a_addr6 = '0; a_wdata6 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_bus", 32'(bus_out), 32'h30);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_b", 32'(grant_b), 32'd1);
    check("rst_acks", 32'({a_ack, b_ack}), 32'd0);
    check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    @(posedge clk); #1;

    // A write 0x5 @0x13
    exp_xact(8'h93, 8'h05);
    a_xact(1'b1, 7'h13, 4'h5, 4'h0);
    check("sram_13", 32'(mem[7'h13]), 32'h5);

    // A read @0x13, data held after ack
    exp_xact(8'h93, 8'h20);
    a_xact(1'b0, 7'h13, 4'h0, 4'h5);
    repeat (3) @(posedge clk);
    #1;
    check("a_rdata_held", 32'(a_rdata), 32'h5);
    check("a_ack_idle", 32'(a_ack), 32'd0);

    // B write 0x6 @0x0A
    exp_xact(8'h8A, 8'h06);
    b_xact(1'b1, 7'h0A, 4'h6, 4'h0);
    check("sram_0a", 32'(mem[7'h0A]), 32'h6);

    // Both request together, A keeps requesting: A, B, A
    exp_xact(8'h8A, 8'h20);
    exp_xact(8'hFF, 8'h0C);
    exp_xact(8'hFF, 8'h20);
    fork
      begin
        a_xact(1'b0, 7'h0A, 4'h0, 4'h6);
        a_xact(1'b0, 7'h7F, 4'h0, 4'hC);
      end
      b_xact(1'b1, 7'h7F, 4'hC, 4'h0);
    join
    check("a_rdata_pre_rst", 32'(a_rdata), 32'hC);
    check("grant_b_pre_rst", 32'(grant_b), 32'd0);

    // Asynchronous reset in the address phase of an A write
    a_req = 1'b1; a_we = 1'b1; a_addr = 7'h40; a_wdata = 4'h3;
    @(posedge clk);
    #3 rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    check("arst_bus", 32'(bus_out), 32'h30);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_grant_b", 32'(grant_b), 32'd1);
    check("arst_acks", 32'({a_ack, b_ack}), 32'd0);
    check("arst_a_rdata", 32'(a_rdata), 32'd0);
    check("arst_b_rdata", 32'(b_rdata), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("sram_40", 32'(mem[7'h40]), 32'h0);

    // Reset during the data phase of a B read (SRAM[0x13]=5)
    exp_bus_q.push_back(8'h93);
    exp_bus_q.push_back(8'h20);
    b_req = 1'b1; b_we = 1'b0; b_addr = 7'h13;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (bus_out == 8'h20);
    end
    if (!seen) fail("b_data_phase_timeout", 32'(bus_out));
    #1 rst_n = 1'b0;
    b_req = 1'b0;
    #1;
    check("drst_b_ack", 32'(b_ack), 32'd0);
    check("drst_b_rdata", 32'(b_rdata), 32'd0);
    check("drst_bus", 32'(bus_out), 32'h30);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_b_ack", 32'(b_ack), 32'd0);
      check("post_rst_b_rdata", 32'(b_rdata), 32'd0);
    end

    // Stretched build: 2 address cycles, 4 data cycles, ack in cycle 7
    @(posedge clk); #1;
    a_req6 = 1'b1; a_we6 = 1'b0; a_addr6 = 7'h55;
    @(posedge clk);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      exp6 = (i <= 2) ? 8'hD5 : ((i <= 6) ? 8'h20 : 8'h30);
      check("bus6", 32'(bus_out6), 32'(exp6));
      check("ack6", 32'(a_ack6), 32'(i == 7));
      check("busy6", 32'(busy6), 32'd1);
    end
    check("rdata6", 32'(a_rdata6), 32'h9);
    check("grant_b6", 32'(grant_b6), 32'd0);
    @(posedge clk); #1;
    a_req6 = 1'b0;
    repeat (2) @(negedge clk);
    check("busy6_idle", 32'(busy6), 32'd0);

    check("bus_q_drained", 32'(exp_bus_q.size()), 32'd0);
    check("a_q_drained", 32'(exp_a_q.size()), 32'd0);
    check("b_q_drained", 32'(exp_b_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
